johnson_stepper: RTL and testbench
==================================

Name: johnson_stepper

Overview:
Command-driven sequencer that advances an n-bit Johnson phase pattern (2n states) forward or backward by a requested number of steps, at a programmable step period. Intended for stepper-motor and multi-phase drive outputs. A host issues move commands over a valid/ready handshake. The block paces the steps, keeps position between commands, and pulses done when a move completes or is aborted.

Parameters:
n, 4, phase output width; must be >= 2
cw, 16, width of the step-count field
dw, 16, width of the step-period field, in clk cycles

Ports:
clk  in  1  system clock; all logic on the rising edge
clr_n  in  1  asynchronous clear, active low
valid  in  1  command present on steps/dir/period
ready  out  1  block idle and able to accept a command
steps  in  cw  number of steps to take; 0 is legal
dir  in  1  0 = forward, 1 = reverse
period  in  dw  clk cycles per step; 0 is treated as 1
abort  in  1  synchronous stop request for the current move
busy  out  1  move in progress
done  out  1  one-cycle pulse when a move ends (completed, aborted or zero-length)
out  out  n  Johnson phase pattern

Behaviour:
- Reset (clr_n low, asynchronous):
  - out=0, ready=1, busy=0, done=0.
  - Step counter and period timer are cleared.
  - Any in-flight command is discarded.
  - Reset is asserted asynchronously; release is sampled on clk.
- Handshake:
  - ready = ~busy.
  - A command is accepted at a clk edge where valid & ready are both 1.
  - steps, dir and period are latched at accept; later changes to these inputs have no effect on the running move.
  - valid while busy is ignored; there is no queueing.
- Step functions:
  - Forward: out <= {out[n-2:0], ~out[n-1]}.
  - Reverse: out <= {~out[0], out[n-1:1]}.
  - Sequence wraps every 2n steps.
  - out holds its value between moves; position persists until the next move or reset.
- States:
  - IDLE: busy=0. On accept with steps=0, go to IDLE and pulse done on the next edge; out is unchanged and busy is never asserted. On accept with steps>0, go to RUN and load timer with P-1, where P = max(period,1).
  - RUN: busy=1. Timer decrements each cycle.
  - When timer==0 and remaining>1: step out, decrement remaining, reload timer with P-1.
  - When timer==0 and remaining==1: step out, assert done for one cycle, set busy=0, go to IDLE.
- Timing:
  - Accept at edge E0.
  - out updates at edges E0+P, E0+2P, ..., E0+S*P.
  - done and ready rise at edge E0+S*P.
  - The earliest next accept is edge E0+S*P+1.
- Abort:
  - Sampled only in RUN.
  - At the next edge: no further step, done pulses, busy=0, out holds its current value.
  - If abort and the final step coincide, the step is taken and done pulses once.
  - Abort in IDLE is ignored; an accept in the same cycle proceeds normally.
- done is exactly one cycle wide per command.
- Counter widths: remaining is cw bits, timer is dw bits. Maximum move is 2^cw-1 steps; maximum period is 2^dw-1 cycles.

Test Plan:
1. Reset: hold clr_n=0 with valid=1 -> out=0000, ready=1, busy=0, done=0; no accept occurs until clr_n=1.
2. n=4, forward, steps=5, period=3 -> out=0001, 0011, 0111, 1111, 1110 at E0+3/6/9/12/15; busy high E0..E0+14; done one cycle at E0+15.
3. Then reverse, steps=3, period=0 (treated as 1) -> out=1111, 0111, 0011 on three consecutive edges; done with the last step; new valid held high is accepted one edge later.
4. Forward from 0000, steps=8, period=1 -> passes through all 8 states and returns to 0000; done once. Then steps=0 -> done one cycle after accept, out unchanged, busy stays 0.
5. Forward, steps=10, period=4, abort after the 2nd step (out=0011) -> no further out change, done at the next edge, ready=1; new commands are ignored while busy.
6. clr_n pulsed low mid-move (out=0111) -> out=0000 and busy=0 immediately, with no clk edge needed; after release, no steps occur and done stays 0.

Source files
------------

// File: rtl/johnson_stepper.sv
// Command-driven Johnson phase sequencer: steps an n-bit Johnson pattern
// forward or backward a requested number of times at a programmable period.
//
// state | meaning
// ------+--------------------------------------------------------------
// idle  | no move in progress; ready=1, accepts a command on valid
// run   | move in progress; timer paces steps, remaining counts them down
module johnson_stepper #(
    parameter int n  = 4,
    parameter int cw = 16,
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          valid,
    output logic          ready,
    input  logic [cw-1:0] steps,
    input  logic          dir,
    input  logic [dw-1:0] period,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  out
);

    typedef enum logic {
        idle = 1'b0,
        run  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [cw-1:0] remaining, remaining_nx;
    logic [dw-1:0] timer, timer_nx;
    logic [dw-1:0] reload, reload_nx;
    logic          dir_q, dir_nx;
    logic [n-1:0]  out_nx;
    logic          done_nx;

    logic [dw-1:0] period_m1;
    logic [n-1:0]  step_fwd;
    logic [n-1:0]  step_rev;
    logic [n-1:0]  step_out;

    // A zero period behaves like a period of one cycle.
    assign period_m1 = (period == '0) ? '0 : period - dw'(1);
    assign step_fwd  = {out[n-2:0], ~out[n-1]};
    assign step_rev  = {~out[0], out[n-1:1]};
    assign step_out  = dir_q ? step_rev : step_fwd;

    assign busy  = (state == run);
    assign ready = ~busy;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= idle;
            remaining <= '0;
            timer     <= '0;
            reload    <= '0;
            dir_q     <= 1'b0;
            out       <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            timer     <= timer_nx;
            reload    <= reload_nx;
            dir_q     <= dir_nx;
            out       <= out_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        timer_nx     = timer;
        reload_nx    = reload;
        dir_nx       = dir_q;
        out_nx       = out;
        done_nx      = 1'b0;
        case (state)
            idle: begin
                if (valid) begin
                    if (steps == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx     = run;
                        remaining_nx = steps;
                        timer_nx     = period_m1;
                        reload_nx    = period_m1;
                        dir_nx       = dir;
                    end
                end
            end
            run: begin
                // The final step wins over a coincident abort.
                if (timer == '0 && remaining == cw'(1)) begin
                    out_nx       = step_out;
                    done_nx      = 1'b1;
                    remaining_nx = '0;
                    state_nx     = idle;
                end else if (abort) begin
                    done_nx      = 1'b1;
                    remaining_nx = '0;
                    timer_nx     = '0;
                    state_nx     = idle;
                end else if (timer == '0) begin
                    out_nx       = step_out;
                    remaining_nx = remaining - cw'(1);
                    timer_nx     = reload;
                end else begin
                    timer_nx = timer - dw'(1);
                end
            end
            default: state_nx = idle;
        endcase
    end

endmodule

// File: tb/tb_johnson_stepper.sv
// Bench for johnson_stepper: directed scenarios plus random commands, all
// compared every cycle against a position/schedule model of the stepper.
module tb_johnson_stepper;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          clr_n = 1'b1;
    logic          valid = 1'b0;
    logic          dir = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] steps = '0;
    logic [DW-1:0] period = '0;
    logic          ready, busy, done;
    logic [N-1:0]  out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    johnson_stepper #(.n(N), .cw(CW), .dw(DW)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .valid  (valid),
        .ready  (ready),
        .steps  (steps),
        .dir    (dir),
        .period (period),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .out    (out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Johnson position k (0..2N-1) counted forward from all-zeros.
    function automatic logic [N-1:0] pat(input int k);
        logic [N-1:0] all1;
        all1 = '1;
        if (k <= N) return N'((1 << k) - 1);
        return all1 & ~N'((1 << (k - N)) - 1);
    endfunction

    // Model: position index plus the accept edge; step edges are t0 + j*P.
    bit     m_busy = 0;
    bit     m_done = 0;
    bit     m_dir  = 0;
    int     m_pos  = 0;
    int     m_s    = 0;
    int     m_p    = 1;
    longint cyc    = 0;
    longint t0     = 0;

    function automatic int adv(input int pos, input bit d);
        return d ? (pos + 2*N - 1) % (2*N) : (pos + 1) % (2*N);
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_busy = 0;
            m_done = 0;
            m_pos  = 0;
        end else begin
            longint el;
            bit     due;
            cyc++;
            m_done = 0;
            if (m_busy) begin
                el  = cyc - t0;
                due = (el % m_p) == 0;
                if (due && (el / m_p) == m_s) begin
                    m_pos  = adv(m_pos, m_dir);
                    m_done = 1;
                    m_busy = 0;
                end else if (abort) begin
                    m_done = 1;
                    m_busy = 0;
                end else if (due) begin
                    m_pos = adv(m_pos, m_dir);
                end
            end else if (valid) begin
                t0    = cyc;
                m_s   = int'(steps);
                m_p   = (period == 0) ? 1 : int'(period);
                m_dir = dir;
                if (steps == 0) m_done = 1;
                else m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("out",   32'(out),   32'(pat(m_pos)));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("ready", 32'(ready), 32'(!m_busy));
        chk("done",  32'(done),  32'(m_done));
    end

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [N-1:0] tbl [8];
        int dcount;
        tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

        // 1: reset with valid held high
        #1 clr_n = 1'b0;
        valid = 1'b1; steps = 5; period = 3;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(out),   32'(0));
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_done",  32'(done),  32'(0));
        valid = 1'b0;
        clr_n = 1'b1;
        @(negedge clk);
        chk("rst_noaccept", 32'(busy), 32'(0));

        // 2: forward 5 steps, period 3
        valid = 1'b1; steps = 5; dir = 1'b0; period = 3;
        @(negedge clk);
        valid = 1'b0;
        chk("t2_busy_e0", 32'(busy), 32'(1));
        repeat (3) @(negedge clk);
        chk("t2_out_e3", 32'(out), 32'(4'b0001));
        repeat (11) @(negedge clk);
        chk("t2_out_e14",  32'(out),  32'(4'b1111));
        chk("t2_busy_e14", 32'(busy), 32'(1));
        chk("t2_done_e14", 32'(done), 32'(0));
        @(negedge clk);
        chk("t2_out_e15",   32'(out),   32'(4'b1110));
        chk("t2_done_e15",  32'(done),  32'(1));
        chk("t2_ready_e15", 32'(ready), 32'(1));

        // 3: reverse 3 steps, period 0; next command held valid throughout
        valid = 1'b1; steps = 3; dir = 1'b1; period = 0;
        @(negedge clk);
        steps = 2; dir = 1'b0; period = 2;
        chk("t3_out_e0", 32'(out), 32'(4'b1110));
        @(negedge clk);
        chk("t3_out_e1", 32'(out), 32'(4'b1111));
        @(negedge clk);
        chk("t3_out_e2", 32'(out), 32'(4'b0111));
        @(negedge clk);
        chk("t3_out_e3",  32'(out),  32'(4'b0011));
        chk("t3_done_e3", 32'(done), 32'(1));
        @(negedge clk);
        chk("t3_next_accept", 32'(busy), 32'(1));
        chk("t3_done_e4",     32'(done), 32'(0));
        valid = 1'b0;
        wait_idle(40);
        @(negedge clk);
        chk("t3_out_final", 32'(out), 32'(4'b1111));

        // 4: return to zero, then a full forward revolution
        valid = 1'b1; steps = 4; dir = 1'b0; period = 1;
        @(negedge clk);
        valid = 1'b0;
        wait_idle(40);
        @(negedge clk);
        chk("t4_home", 32'(out), 32'(0));
        valid = 1'b1; steps = 8; dir = 1'b0; period = 1;
        @(negedge clk);
        valid = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_rev_out", 32'(out), 32'(tbl[i]));
            dcount += int'(done);
        end
        repeat (3) begin
            @(negedge clk);
            dcount += int'(done);
        end
        chk("t4_done_count", 32'(dcount), 32'(1));
        valid = 1'b1; steps = 0; period = 5;
        @(negedge clk);
        valid = 1'b0;
        chk("t4_zero_done", 32'(done), 32'(1));
        chk("t4_zero_busy", 32'(busy), 32'(0));
        chk("t4_zero_out",  32'(out),  32'(0));
        @(negedge clk);
        chk("t4_zero_done_w", 32'(done), 32'(0));

        // 5: abort after second step; a command during the move is ignored
        valid = 1'b1; steps = 10; dir = 1'b0; period = 4;
        @(negedge clk);
        valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_out_2nd", 32'(out), 32'(4'b0011));
        abort = 1'b1;
        valid = 1'b1; steps = 3; dir = 1'b1; period = 1;
        @(negedge clk);
        chk("t5_abort_done",  32'(done),  32'(1));
        chk("t5_abort_ready", 32'(ready), 32'(1));
        chk("t5_abort_out",   32'(out),   32'(4'b0011));
        abort = 1'b0;
        valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_hold_out",  32'(out),  32'(4'b0011));
        chk("t5_hold_busy", 32'(busy), 32'(0));

        // 6: asynchronous clear mid-move
        valid = 1'b1; steps = 10; dir = 1'b0; period = 2;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_out_pre", 32'(out), 32'(4'b0111));
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("t6_async_out",   32'(out),   32'(0));
        chk("t6_async_busy",  32'(busy),  32'(0));
        chk("t6_async_ready", 32'(ready), 32'(1));
        @(negedge clk);
        clr_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            dcount += int'(done);
        end
        chk("t6_no_done", 32'(dcount), 32'(0));
        chk("t6_out_post", 32'(out), 32'(0));

        // random commands, aborts and periods
        repeat (3000) begin
            @(negedge clk);
            valid  = ($urandom_range(0, 3) == 0);
            steps  = CW'($urandom_range(0, 9));
            dir    = 1'($urandom_range(0, 1));
            period = DW'($urandom_range(0, 4));
            abort  = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        valid = 1'b0;
        abort = 1'b0;
        wait_idle(100);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
